// File: rtl/stopwatch_btn_conditioner.sv
// Stopwatch push-button conditioner: 2-FF sync, per-button debounce, rising-edge
// detect and fixed-priority (clr > stop > lap > start) single-pulse arbitration.
module stopwatch_btn_conditioner #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  input  logic       en,
  output logic       start_p,
  output logic       lap_p,
  output logic       stop_p,
  output logic       clr_p,
  output logic [3:0] btn_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [3:0]       s1_q, s2_q;
  logic [3:0]       db_q, db_prev_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [3:0]       rise;
  logic [3:0]       pulse_d, pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
    end
  end

  // Any sample agreeing with the debounced level restarts that button's count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (s2_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          db_q[i]  <= s2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign rise = db_q & ~db_prev_q;

  always_comb begin
    pulse_d = '0;
    if (rise[3])      pulse_d = 4'b1000;
    else if (rise[2]) pulse_d = 4'b0100;
    else if (rise[1]) pulse_d = 4'b0010;
    else if (rise[0]) pulse_d = 4'b0001;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_prev_q <= '0;
      pulse_q   <= '0;
    end else begin
      db_prev_q <= db_q;
      pulse_q   <= en ? pulse_d : '0;
    end
  end

  assign btn_level = db_q;
  assign start_p   = pulse_q[0];
  assign lap_p     = pulse_q[1];
  assign stop_p    = pulse_q[2];
  assign clr_p     = pulse_q[3];

endmodule

// File: tb/tb_stopwatch_btn_conditioner.sv
// Self-checking bench: segment table, hand-written bounce/reset sequences and a
// random run, all compared cycle by cycle against a sliding-window reference model.
module tb_stopwatch_btn_conditioner;

  localparam int DB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic       en;
  logic       start_p, lap_p, stop_p, clr_p;
  logic [3:0] btn_level;

  always #5 clk = ~clk;

  stopwatch_btn_conditioner #(.DB_CYCLES(DB), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .en       (en),
    .start_p  (start_p),
    .lap_p    (lap_p),
    .stop_p   (stop_p),
    .clr_p    (clr_p),
    .btn_level(btn_level)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a button's level flips once the DB most recent synchronized
  // samples (raw delayed two edges) all disagree with it.
  logic [3:0] hist[$];
  logic [3:0] m_db, m_rose, m_pulse;

  int         edge_no;
  int         pcount[4];
  int         first_pulse[4];
  int         first_chg[4];
  logic [3:0] lvl_mark;

  typedef struct {
    logic [3:0] raw;
    logic       en;
    int         cycles;
    logic [3:0] exp_level;
    logic [3:0] exp_pulsed;
    int         exp_chg;
    int         exp_pulse;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] prio(input logic [3:0] r);
    if (r[3]) return 4'b1000;
    if (r[2]) return 4'b0100;
    if (r[1]) return 4'b0010;
    if (r[0]) return 4'b0001;
    return 4'b0000;
  endfunction

  function automatic int earliest(input int a[4]);
    int m = -1;
    for (int i = 0; i < 4; i++)
      if (a[i] >= 0 && (m < 0 || a[i] < m)) m = a[i];
    return m;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (DB + 2) hist.push_back(4'b0000);
    m_db = '0; m_rose = '0; m_pulse = '0;
  endtask

  task automatic model_edge(input logic [3:0] raw, input logic e);
    logic [3:0] nxt;
    hist.push_front(raw);
    if (hist.size() > DB + 2) void'(hist.pop_back());
    nxt = m_db;
    for (int b = 0; b < 4; b++) begin
      bit all_differ = 1'b1;
      for (int k = 2; k < DB + 2; k++)
        if (hist[k][b] == m_db[b]) all_differ = 1'b0;
      if (all_differ) nxt[b] = ~m_db[b];
    end
    m_pulse = e ? prio(m_rose) : 4'b0000;
    m_rose  = nxt & ~m_db;
    m_db    = nxt;
  endtask

  task automatic mark();
    edge_no  = 0;
    lvl_mark = btn_level;
    for (int b = 0; b < 4; b++) begin
      pcount[b] = 0; first_pulse[b] = -1; first_chg[b] = -1;
    end
  endtask

  task automatic step(input logic [3:0] raw, input logic e, input logic r);
    logic [3:0] p;
    @(negedge clk);
    btn_raw = raw; en = e; rst_n = r;
    if (!r) begin
      #1;
      check("reset_async", {btn_level, clr_p, stop_p, lap_p, start_p}, 0);
    end
    @(posedge clk);
    if (rst_n) model_edge(raw, e);
    else       model_reset();
    #1;
    p = {clr_p, stop_p, lap_p, start_p};
    check("cycle", {btn_level, p}, {m_db, m_pulse});
    check("onehot", int'($countones(p) <= 1), 1);
    for (int b = 0; b < 4; b++) begin
      if (p[b]) begin
        pcount[b]++;
        if (first_pulse[b] < 0) first_pulse[b] = edge_no;
      end
      if (btn_level[b] != lvl_mark[b] && first_chg[b] < 0) first_chg[b] = edge_no;
    end
    edge_no++;
  endtask

  initial begin
    logic [3:0] mask;
    logic [3:0] raw;
    int         total;

    rst_n = 1'b0; btn_raw = '0; en = 1'b1;
    model_reset();
    #1;
    check("reset_state", {btn_level, clr_p, stop_p, lap_p, start_p}, 0);
    repeat (3) step(4'b0000, 1'b1, 1'b0);

    //            raw      en    cyc  level    pulsed   chg  pulse
    vecs.push_back('{4'b0001, 1'b1, 40, 4'b0001, 4'b0001, 17,  18});
    vecs.push_back('{4'b0000, 1'b1, 30, 4'b0000, 4'b0000, 17,  -1});
    vecs.push_back('{4'b1000, 1'b1, 10, 4'b0000, 4'b0000, -1,  -1});
    vecs.push_back('{4'b0000, 1'b1, 30, 4'b0000, 4'b0000, -1,  -1});
    vecs.push_back('{4'b0110, 1'b1, 40, 4'b0110, 4'b0100, 17,  18});
    vecs.push_back('{4'b0000, 1'b1, 30, 4'b0000, 4'b0000, 17,  -1});
    vecs.push_back('{4'b0001, 1'b0, 40, 4'b0001, 4'b0000, 17,  -1});
    vecs.push_back('{4'b0001, 1'b1, 20, 4'b0001, 4'b0000, -1,  -1});
    vecs.push_back('{4'b0000, 1'b1, 30, 4'b0000, 4'b0000, 17,  -1});

    for (int v = 0; v < vecs.size(); v++) begin
      mark();
      repeat (vecs[v].cycles) step(vecs[v].raw, vecs[v].en, 1'b1);
      mask = '0; total = 0;
      for (int b = 0; b < 4; b++) begin
        mask[b] = (pcount[b] != 0);
        total += pcount[b];
      end
      check($sformatf("vec%0d_level", v), btn_level, vecs[v].exp_level);
      check($sformatf("vec%0d_pulsed", v), mask, vecs[v].exp_pulsed);
      check($sformatf("vec%0d_npulse", v), total, $countones(vecs[v].exp_pulsed));
      check($sformatf("vec%0d_chg_edge", v), earliest(first_chg), vecs[v].exp_chg);
      check($sformatf("vec%0d_pulse_edge", v), earliest(first_pulse), vecs[v].exp_pulse);
    end

    // Bounce on lap: 3-cycle runs never reach the debounce threshold.
    mark();
    for (int i = 0; i < 30; i++) step(((i / 3) % 2 == 0) ? 4'b0010 : 4'b0000, 1'b1, 1'b1);
    check("bounce_no_pulse", pcount[0] + pcount[1] + pcount[2] + pcount[3], 0);
    check("bounce_level", btn_level, 4'b0000);
    mark();
    repeat (40) step(4'b0010, 1'b1, 1'b1);
    check("bounce_lap_edge", first_pulse[1], 18);
    check("bounce_lap_count", pcount[1], 1);
    repeat (30) step(4'b0000, 1'b1, 1'b1);

    // Reset mid-count, then again while the debounced level is high.
    repeat (8) step(4'b0001, 1'b1, 1'b1);
    repeat (3) step(4'b0001, 1'b1, 1'b0);
    mark();
    repeat (25) step(4'b0001, 1'b1, 1'b1);
    check("rst1_pulse_edge", first_pulse[0], 18);
    check("rst1_level_edge", first_chg[0], 17);
    check("rst1_count", pcount[0], 1);
    repeat (3) step(4'b0001, 1'b1, 1'b0);
    check("rst2_level_cleared", btn_level, 4'b0000);
    mark();
    repeat (25) step(4'b0001, 1'b1, 1'b1);
    check("rst2_pulse_edge", first_pulse[0], 18);
    check("rst2_count", pcount[0], 1);
    repeat (30) step(4'b0000, 1'b1, 1'b1);

    // Random buttons with long-ish holds, occasional en=0 and rare resets.
    raw = '0;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(24) == 0) raw[b] = ~raw[b];
      step(raw, ($urandom_range(9) != 0), ($urandom_range(299) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
